// File: rtl/regfile_sb_pkg.sv
// Shared constants for the decode-stage register file with pending-write scoreboard.
package regfile_sb_pkg;

  localparam logic        RstEnable   = 1'b0;
  localparam logic        RstDisable  = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic        ReadEnable  = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

endpackage

// File: rtl/regfile_sb_if.sv
// Read/write/issue bus between decode logic (master) and the register file (slave).
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);

  logic [NRD-1:0]        rd_en;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wr_en;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  flush;
  logic [ADDR_W:0]       busy_cnt;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, busy_cnt
  );

endinterface

// File: rtl/regfile_fwd_mux.sv
// One read port: zero-register masking, same-cycle write forwarding, busy lookup.
module regfile_fwd_mux
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  input  logic [DATA_W-1:0]     i_stored,
  input  logic                  i_busy,
  input  logic [NWR-1:0]        i_wr_en,
  input  logic [NWR*ADDR_W-1:0] i_wr_addr,
  input  logic [NWR*DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0]     o_rd_data,
  output logic                  o_rd_busy
);

  logic w_zero_hit;

  assign w_zero_hit = (ZERO_REG != 0) && (i_rd_addr == '0);

  always_comb begin
    o_rd_data = DATA_W'(ZeroWord);
    o_rd_busy = 1'b0;
    if ((i_rd_en == ReadEnable) && !w_zero_hit) begin
      o_rd_data = i_stored;
      o_rd_busy = i_busy;
      // Ascending scan so the highest-indexed matching write port wins.
      for (int j = 0; j < NWR; j++) begin
        if ((i_wr_en[j] == WriteEnable) &&
            (i_wr_addr[j*ADDR_W +: ADDR_W] == i_rd_addr)) begin
          o_rd_data = i_wr_data[j*DATA_W +: DATA_W];
          o_rd_busy = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register pending-write scoreboard and busy counter.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  regfile_sb_if.slave bus
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_busy;
  logic [ADDR_W:0]       r_busy_cnt;

  logic [DATA_W-1:0]     w_wr_val [NUM_REGS];
  logic [NUM_REGS-1:0]   w_wr_hit;
  logic [NUM_REGS-1:0]   w_iss_vec;
  logic [NUM_REGS-1:0]   w_busy_next;
  logic [ADDR_W:0]       w_sets;
  logic [ADDR_W:0]       w_clrs;
  logic [ADDR_W:0]       w_busy_cnt_next;
  logic [NRD-1:0]        w_rd_en;
  logic [NRD*DATA_W-1:0] w_rd_data;
  logic [NRD-1:0]        w_rd_busy;

  // Resolve all write ports per register; later ports overwrite earlier ones.
  always_comb begin
    logic [ADDR_W-1:0] v_addr;
    w_wr_hit = '0;
    v_addr   = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_wr_val[r] = r_regs[r];
    end
    for (int j = 0; j < NWR; j++) begin
      v_addr = bus.wr_addr[j*ADDR_W +: ADDR_W];
      if ((bus.wr_en[j] == WriteEnable) && !((ZERO_REG != 0) && (v_addr == '0))) begin
        w_wr_hit[v_addr] = 1'b1;
        w_wr_val[v_addr] = bus.wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_iss_vec = '0;
    if (bus.iss_en && !((ZERO_REG != 0) && (bus.iss_addr == '0))) begin
      w_iss_vec[bus.iss_addr] = 1'b1;
    end
  end

  // Flush beats issue, issue beats write-back clear.
  assign w_busy_next = bus.flush ? '0 : ((r_busy & ~w_wr_hit) | w_iss_vec);

  always_comb begin
    w_sets = '0;
    w_clrs = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_sets = w_sets + {{ADDR_W{1'b0}}, (w_busy_next[r] & ~r_busy[r])};
      w_clrs = w_clrs + {{ADDR_W{1'b0}}, (r_busy[r] & ~w_busy_next[r])};
    end
  end

  assign w_busy_cnt_next = bus.flush ? '0 : (r_busy_cnt + w_sets - w_clrs);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RstEnable) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_wr_hit[r]) begin
          r_regs[r] <= w_wr_val[r];
        end
      end
      r_busy     <= w_busy_next;
      r_busy_cnt <= w_busy_cnt_next;
    end
  end

  // Gating the enables forces every read port quiet while reset is held.
  assign w_rd_en = bus.rd_en & {NRD{i_rst_n == RstDisable}};

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_rd_addr;
      assign w_rd_addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];

      regfile_fwd_mux #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
      ) u_fwd_mux (
        .i_rd_en   (w_rd_en[gi]),
        .i_rd_addr (w_rd_addr),
        .i_stored  (r_regs[w_rd_addr]),
        .i_busy    (r_busy[w_rd_addr]),
        .i_wr_en   (bus.wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .o_rd_data (w_rd_data[gi*DATA_W +: DATA_W]),
        .o_rd_busy (w_rd_busy[gi])
      );
    end
  endgenerate

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_busy  = w_rd_busy;
  assign bus.busy_cnt = r_busy_cnt;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port register file with a per-register pending-write scoreboard; the next generation of the decode-stage register file.
- Serves NRD combinational read ports and NWR write-back ports, with same-cycle write-to-read forwarding.
- Tracks registers with an issued-but-not-written-back result, so decode can stall on RAW hazards without a separate scoreboard.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; register count NUM_REGS = 2**ADDR_W
NRD, 2, number of read ports
NWR, 2, number of write ports
ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
rd_en  in  NRD  per-port read enable
rd_addr  in  NRD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NRD*DATA_W  read data; port i at [i*DATA_W +: DATA_W]
rd_busy  out  NRD  per-port flag: addressed register has a pending write
wr_en  in  NWR  per-port write enable
wr_addr  in  NWR*ADDR_W  write addresses
wr_data  in  NWR*DATA_W  write data
iss_en  in  1  mark destination register pending (instruction issued)
iss_addr  in  ADDR_W  destination register being issued
flush  in  1  clear all pending bits (pipeline flush)
busy_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
Reset:
- rst=0 asynchronously clears all registers and busy bits, and sets busy_cnt=0.
- While rst=0, rd_data=0 and rd_busy=0 on all ports.
- Reset mid-operation discards all pending state, with no partial writes.

Write path (posedge clk, rst=1):
- Each port with wr_en[j]=1 writes wr_data[j] to regs[wr_addr[j]].
- Two ports writing the same address: the highest index wins.
- With ZERO_REG=1, writes to address 0 are ignored.

Read path (combinational, zero latency):
- rd_en[i]=0 -> rd_data[i]=0 and rd_busy[i]=0.
- ZERO_REG=1 and rd_addr[i]=0 -> rd_data[i]=0 and rd_busy[i]=0.
- Any wr_en[j]=1 with wr_addr[j]=rd_addr[i] (write not suppressed) -> rd_data[i] = wr_data of the highest such j (forwarding), and rd_busy[i]=0.
- Otherwise rd_data[i] = regs[rd_addr[i]] and rd_busy[i] = busy[rd_addr[i]].
- rd_busy does not reflect iss_en in the same cycle. Issue takes effect at the next edge.

Scoreboard (posedge clk, rst=1), per register r, in priority order:
- flush=1 -> busy[r]=0 for all r; iss_en is ignored that cycle.
- Else iss_en=1 and iss_addr=r -> busy[r]=1. This holds even if a write to r occurs in the same cycle: the newer issue wins.
- Else any enabled write to r -> busy[r]=0.
- Else busy[r] holds.
- iss_en to an already-busy register leaves it busy. There is no counting and no error.
- iss_en to address 0 with ZERO_REG=1 is ignored.

busy_cnt:
- Registered count of set busy bits, updated every edge as old count + sets - clears.
- Goes to 0 on flush.
- Range 0..NUM_REGS (NUM_REGS fits in ADDR_W+1 bits).
- Must always equal the population count of the busy bits.

Decomposition:
Shared package (common defines header):
- RstEnable=1'b0 and RstDisable=1'b1 for this block.
- WriteEnable, ReadEnable, ZeroWord.
Sub-module regfile_fwd_mux, one instance per read port:
- Inputs: rd_en, rd_addr, stored data, busy bit, all write ports.
- Outputs: forwarded rd_data and rd_busy.
- Implements the priority/zero/forward rules above.
Top level holds the storage array, the busy vector and busy_cnt.

Test Plan:
- Reset then read all 32 regs on both ports -> rd_data=0, rd_busy=0, busy_cnt=0. Assert rst=0 mid-burst -> outputs 0 immediately, without waiting for a clock edge.
- Write port0 r5=0xDEADBEEF and port1 r5=0x12345678 same cycle, reading r5 that cycle -> forwarded 0x12345678. Next cycle, stored read -> 0x12345678.
- Write r0=0xFFFFFFFF (ZERO_REG=1) -> read r0=0, busy_cnt unchanged. With iss_en at r0 -> rd_busy=0.
- Issue r7 -> next cycle rd_busy=1, busy_cnt=1. Write r7=0xA5 -> same-cycle rd_busy=0 and rd_data=0xA5; next cycle busy_cnt=0.
- Same cycle: iss_en r9 and write r9=0x11 -> after edge busy[r9]=1, regs[r9]=0x11. Issue r3, r4, r9 over three cycles, then flush together with iss_en r10 -> busy_cnt=0, r10 not busy.
- Random 10k-cycle run with model check -> busy_cnt equals popcount(busy) and rd_data matches the reference array on every cycle.
